// File: rtl/unsigned_precision_expander_pkg.sv
`default_nettype none
// ============================================================================
// Module  : unsigned_precision_expander_pkg
// Purpose : Shared numeric definitions for the precision expansion blocks.
//           Holds the reconstruction mode encoding used by the rounding /
//           expansion logic.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package unsigned_precision_expander_pkg;

  localparam int MODE_WIDTH = 2;

  // Reconstruction mode carried alongside each sample.
  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_ZERO_PAD  = 2'd0,
    MODE_MIDPOINT  = 2'd1,
    MODE_REPLICATE = 2'd2,
    MODE_RESERVED  = 2'd3
  } mode_e;

endpackage : unsigned_precision_expander_pkg
`default_nettype wire

// File: rtl/unsigned_expand_core.sv
`default_nettype none
// ============================================================================
// Module  : unsigned_expand_core
// Purpose : Combinational widening of a narrow unsigned sample into the wide
//           format. The narrow value always lands in the top bits; the low
//           FILL bits depend on the reconstruction mode.
// Ports   : data     in  [DATA_WIDTH_IN-1:0]   narrow sample
//           mode     in  mode_e                reconstruction mode
//           expanded out [DATA_WIDTH_OUT-1:0]  widened sample
// Revision: 1.0 - initial release
// ============================================================================
module unsigned_expand_core
  import unsigned_precision_expander_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 12,
  parameter int DATA_WIDTH_OUT = 16
) (
  input  logic [DATA_WIDTH_IN-1:0]  data,
  input  mode_e                     mode,
  output logic [DATA_WIDTH_OUT-1:0] expanded
);

  localparam int FILL = DATA_WIDTH_OUT - DATA_WIDTH_IN;

  generate
    if (FILL < 0) begin : g_bad_width
      $error("unsigned_expand_core: DATA_WIDTH_OUT must be >= DATA_WIDTH_IN");
    end else if (FILL == 0) begin : g_pass
      // No fraction bits to fill: every mode is an identity.
      assign expanded = data;
    end else begin : g_fill
      logic [FILL-1:0] repl_bits;
      logic [FILL-1:0] mid_bits;

      // Replicate the sample MSB-first into the fill field; wraps around the
      // sample when the fill is wider than the sample itself.
      always_comb begin
        repl_bits = '0;
        for (int i = 0; i < FILL; i++) begin
          repl_bits[FILL-1-i] = data[DATA_WIDTH_IN-1-(i % DATA_WIDTH_IN)];
        end
      end

      // Half an LSB of the narrow format: the centre of the truncation bin.
      always_comb begin
        mid_bits         = '0;
        mid_bits[FILL-1] = 1'b1;
      end

      always_comb begin
        case (mode)
          MODE_MIDPOINT:  expanded = {data, mid_bits};
          MODE_REPLICATE: expanded = {data, repl_bits};
          default:        expanded = {data, {FILL{1'b0}}};
        endcase
      end
    end
  endgenerate

endmodule : unsigned_expand_core
`default_nettype wire

// File: rtl/unsigned_precision_expander.sv
`default_nettype none
// ============================================================================
// Module  : unsigned_precision_expander
// Purpose : Two-stage valid/ready pipeline that widens narrow unsigned
//           samples (zero-pad, midpoint, replicate) and counts delivered
//           output beats.
// Ports   : clk        in  rising-edge clock
//           rst        in  synchronous active-high reset
//           s_valid    in  input beat valid
//           s_ready    out input beat accepted when s_valid && s_ready
//           s_data     in  [DATA_WIDTH_IN-1:0] narrow sample
//           s_mode     in  [1:0] reconstruction mode for this beat
//           m_valid    out output beat valid
//           m_ready    in  downstream accepts when m_valid && m_ready
//           m_data     out [DATA_WIDTH_OUT-1:0] reconstructed sample
//           beat_count out [15:0] output transfers, wraps modulo 2^16
// Revision: 1.0 - initial release
// ============================================================================
module unsigned_precision_expander
  import unsigned_precision_expander_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 12,
  parameter int DATA_WIDTH_OUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH_IN-1:0]  s_data,
  input  logic [MODE_WIDTH-1:0]     s_mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH_OUT-1:0] m_data,
  output logic [15:0]               beat_count
);

  logic [DATA_WIDTH_OUT-1:0] expanded;
  logic [DATA_WIDTH_OUT-1:0] s1_data;
  logic                      s1_valid;
  logic                      s2_advance;
  logic                      s_accept;

  unsigned_expand_core #(
    .DATA_WIDTH_IN  (DATA_WIDTH_IN),
    .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
  ) u_core (
    .data     (s_data),
    .mode     (mode_e'(s_mode)),
    .expanded (expanded)
  );

  // S2 may take a new value whenever it is empty or is being drained this
  // cycle; S1 may refill whenever it is empty or is moving into S2.
  assign s2_advance = !m_valid || m_ready;
  assign s_ready    = !s1_valid || s2_advance;
  assign s_accept   = s_valid && s_ready;

  // Control state and the output register (m_data is reset to a known value).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      beat_count <= '0;
    end else begin
      if (s_ready) begin
        s1_valid <= s_valid;
      end
      if (s2_advance) begin
        m_valid <= s1_valid;
        if (s1_valid) begin
          m_data <= s1_data;
        end
      end
      if (m_valid && m_ready) begin
        beat_count <= beat_count + 16'd1;
      end
    end
  end

  // S1 payload carries no reset; it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (s_accept) begin
      s1_data <= expanded;
    end
  end

endmodule : unsigned_precision_expander
`default_nettype wire

// File: tb/tb_unsigned_precision_expander.sv
`default_nettype none
// ============================================================================
// Module  : tb_unsigned_precision_expander
// Purpose : Self-checking bench for unsigned_precision_expander (12->16 and
//           12->12 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_unsigned_precision_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // 12 -> 16 instance
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [11:0] s_data;
  logic [1:0]  s_mode;
  logic [15:0] m_data, beat_count;
  // 12 -> 12 instance
  logic        n_s_valid, n_s_ready, n_m_valid, n_m_ready;
  logic [11:0] n_s_data, n_m_data;
  logic [1:0]  n_s_mode;
  logic [15:0] n_beat_count;

  unsigned_precision_expander #(.DATA_WIDTH_IN(12), .DATA_WIDTH_OUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .beat_count(beat_count)
  );

  unsigned_precision_expander #(.DATA_WIDTH_IN(12), .DATA_WIDTH_OUT(12)) dut_n (
    .clk(clk), .rst(rst),
    .s_valid(n_s_valid), .s_ready(n_s_ready), .s_data(n_s_data), .s_mode(n_s_mode),
    .m_valid(n_m_valid), .m_ready(n_m_ready), .m_data(n_m_data), .beat_count(n_beat_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; resume 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: reconstruct arithmetically for a 4-bit fraction field.
  function automatic logic [15:0] ref_expand(input logic [11:0] d, input logic [1:0] m);
    int unsigned v;
    v = int'(d) * 16;
    case (m)
      2'd1:    v = v + 8;            // half of one narrow LSB
      2'd2:    v = v + int'(d) / 256; // top four sample bits repeated
      default: v = v;
    endcase
    return v[15:0];
  endfunction

  typedef struct {
    logic [11:0] data;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[10];

  logic [15:0] sb_q[$];
  logic [15:0] exp_v, prev_data;
  logic        prev_stall, low_seen;
  int          next_beat, exp_out, n_xfer, guard;
  logic [15:0] base_count;

  initial begin
    tv[0] = '{12'hABC, 2'd0, 16'hABC0};
    tv[1] = '{12'hABC, 2'd1, 16'hABC8};
    tv[2] = '{12'hABC, 2'd2, 16'hABCA};
    tv[3] = '{12'hABC, 2'd3, 16'hABC0};
    tv[4] = '{12'hFFF, 2'd2, 16'hFFFF};
    tv[5] = '{12'h000, 2'd2, 16'h0000};
    tv[6] = '{12'hFFF, 2'd1, 16'hFFF8};
    tv[7] = '{12'h001, 2'd1, 16'h0018};
    tv[8] = '{12'h800, 2'd2, 16'h8008};
    tv[9] = '{12'h000, 2'd1, 16'h0008};

    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_mode = '0; m_ready = 1'b0;
    n_s_valid = 1'b0; n_s_data = '0; n_s_mode = '0; n_m_ready = 1'b1;
    repeat (3) tick;

    // ---------------- reset state ----------------
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_beat_count", beat_count, 0);
    rst = 1'b0;
    tick;
    check("post_rst_s_ready", s_ready, 1);

    // ---------------- table vectors, latency two edges ----------------
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = tv[i].data; s_mode = tv[i].mode; m_ready = 1'b1;
      tick;                       // captured into S1
      s_valid = 1'b0;
      check("vec_early_m_valid", m_valid, 0);
      tick;                       // moved into S2
      check("vec_m_valid", m_valid, 1);
      check($sformatf("vec%0d_m_data", i), m_data, tv[i].exp);
      tick;
    end
    check("vec_beat_count", beat_count, 10);

    // ---------------- equal widths: pass-through in every mode ----------------
    for (int m = 0; m < 4; m++) begin
      n_s_valid = 1'b1; n_s_data = 12'h5A5; n_s_mode = 2'(m);
      tick;
      n_s_valid = 1'b0;
      check("narrow_early_m_valid", n_m_valid, 0);
      tick;
      check("narrow_m_valid", n_m_valid, 1);
      check($sformatf("narrow_mode%0d_m_data", m), n_m_data, 12'h5A5);
      tick;
    end

    // ---------------- stream with backpressure ----------------
    base_count = beat_count;
    next_beat = 1; exp_out = 1; prev_stall = 1'b0; prev_data = '0; low_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_out <= 8; cyc++) begin
      if (prev_stall) begin
        check("stall_m_valid", m_valid, 1);
        check("stall_m_data", m_data, prev_data);
      end
      s_valid = (next_beat <= 8);
      s_data  = 12'(next_beat);
      s_mode  = 2'd0;
      m_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      if (!s_ready && !low_seen) begin
        low_seen = 1'b1;
        check("pending_at_s_ready_drop", 32'(next_beat - exp_out), 2);
      end
      if (s_valid && s_ready) next_beat++;
      if (m_valid && m_ready) begin
        check("stream_order", m_data, 32'(exp_out * 16));
        exp_out++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick;
    end
    s_valid = 1'b0;
    check("stream_all_out", exp_out, 9);
    check("stream_s_ready_dropped", low_seen, 1);
    check("stream_beat_count", beat_count, 32'(base_count + 16'd8));

    // ---------------- reset with beats in flight ----------------
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 12'h0AA; s_mode = 2'd0; tick;
    s_data = 12'h0BB; tick;
    s_valid = 1'b0;
    check("inflight_m_valid", m_valid, 1);
    rst = 1'b1; tick;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_beat_count", beat_count, 0);
    rst = 1'b0; tick;
    check("midrst_s_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 12'h123; s_mode = 2'd0; m_ready = 1'b1;
    tick;
    s_valid = 1'b0;
    n_xfer = 0;
    for (int k = 0; k < 6; k++) begin
      if (m_valid && m_ready) begin
        n_xfer++;
        check("post_rst_data", m_data, 16'h1230);
      end
      tick;
    end
    check("post_rst_xfer_count", n_xfer, 1);
    check("post_rst_beat_count", beat_count, 1);

    // ---------------- beat_count wrap ----------------
    s_valid = 1'b1; s_data = 12'h001; s_mode = 2'd0; m_ready = 1'b1;
    guard = 0;
    while (beat_count != 16'hFFFF && guard < 70000) begin
      tick;
      guard++;
    end
    check("count_reached_ffff", beat_count, 16'hFFFF);
    check("count_wrap_pending_xfer", m_valid, 1);
    tick;
    check("count_wrap", beat_count, 16'h0000);
    s_valid = 1'b0;
    repeat (3) tick;

    // ---------------- randomized traffic vs reference queue ----------------
    base_count = beat_count;
    n_xfer = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall) begin
        check("rnd_stall_m_valid", m_valid, 1);
        check("rnd_stall_m_data", m_data, prev_data);
      end
      s_valid = (cyc < 2990) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      s_data  = 12'($urandom);
      s_mode  = 2'($urandom);
      m_ready = (cyc < 2990) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (m_valid && m_ready) begin
        n_xfer++;
        if (sb_q.size() == 0) begin
          check("rnd_unexpected_beat", 1, 0);
        end else begin
          exp_v = sb_q.pop_front();
          check("rnd_m_data", m_data, exp_v);
        end
      end
      if (s_valid && s_ready) sb_q.push_back(ref_expand(s_data, s_mode));
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick;
    end
    check("rnd_queue_drained", sb_q.size(), 0);
    check("rnd_beat_count", beat_count, 32'(base_count + 16'(n_xfer)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_unsigned_precision_expander
`default_nettype wire

// File: doc/unsigned_precision_expander.md
UNSIGNED_PRECISION_EXPANDER -- requirements
Module: unsigned_precision_expander

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN, default 12, narrow (rounded) unsigned sample width.
REQ-002 SHALL have parameter DATA_WIDTH_OUT, default 16, wide unsigned reconstructed width.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 s_valid  input  1  input beat valid.
REQ-005 s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-006 s_data  input  DATA_WIDTH_IN  unsigned narrow sample.
REQ-007 s_mode  input  2  reconstruction mode, captured with each beat.
REQ-008 m_valid  output  1  output beat valid.
REQ-009 m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-010 m_data  output  DATA_WIDTH_OUT  unsigned reconstructed sample.
REQ-011 beat_count  output  16  count of output beats transferred, wraps modulo 2^16.

Function
REQ-012 F = DATA_WIDTH_OUT - DATA_WIDTH_IN; elaboration SHALL fail if F < 0.
REQ-013 mode 0 (ZERO_PAD): m_data = s_data << F.
REQ-014 mode 1 (MIDPOINT): m_data = (s_data << F) | (1 << (F-1)); bin centre for truncated sources; no overflow possible; F = 0 behaves as ZERO_PAD.
REQ-015 mode 2 (REPLICATE): low F bits filled by repeating s_data MSB-first, truncated to F bits; 0 -> 0, all-ones -> all-ones.
REQ-016 mode 3 reserved, SHALL behave as ZERO_PAD.
REQ-017 F = 0: all modes pass s_data unchanged, still registered through both stages.
REQ-018 Two register stages: S1 holds expanded value plus valid; S2 drives m_data/m_valid.
REQ-019 Latency: beat accepted at edge N SHALL appear on m_valid at edge N+2 when no backpressure.
REQ-020 S2 advance = !m_valid || m_ready; S1 moves into S2 on S2 advance.
REQ-021 s_ready = !S1.valid || S2 advance (combinational from m_ready permitted).
REQ-022 Throughput: one beat per cycle sustained with m_ready held high.
REQ-023 m_data and m_valid SHALL stay stable while m_valid && !m_ready.
REQ-024 Beats SHALL be delivered in acceptance order; no loss, no duplication under any m_ready pattern.
REQ-025 Simultaneous accept and output transfer in one cycle SHALL both complete.
REQ-026 beat_count increments on each m_valid && m_ready; 0xFFFF wraps to 0x0000.

Reset
REQ-027 On rst: S1.valid = 0, m_valid = 0, m_data = 0, beat_count = 0; s_ready = 1 in the cycle after reset releases.
REQ-028 Reset mid-transfer SHALL discard all in-flight beats; no beat held before reset SHALL appear afterwards.
REQ-029 Data registers other than m_data need no reset.

Structure
REQ-030 Mode encoding (ZERO_PAD, MIDPOINT, REPLICATE, RESERVED) SHALL be an enum typedef in the shared numbers package, reused by the rounding blocks.
REQ-031 Combinational expansion SHALL be one sub-module, unsigned_expand_core (inputs data, mode; output wide data), instantiated ahead of S1.
REQ-032 Handshake/pipeline logic and beat_count SHALL live in the top module.

Verification (DATA_WIDTH_IN=12, DATA_WIDTH_OUT=16, F=4)
REQ-033 s_data 0xABC in modes 0/1/2/3, m_ready=1 -> m_data 0xABC0 / 0xABC8 / 0xABCA / 0xABC0, each two cycles after accept.
REQ-034 s_data 0xFFF and 0x000 in mode 2 -> 0xFFFF and 0x0000; 0xFFF in mode 1 -> 0xFFF8.
REQ-035 Stream 0x001..0x008 with m_ready low cycles 3-7 -> s_ready drops after two pending beats; outputs 0x0010..0x0080 in order, m_data stable while stalled, beat_count = 8.
REQ-036 rst asserted with two beats in flight -> next cycle m_valid=0, beat_count=0; post-reset beat 0x123 mode 0 -> only 0x1230 emerges.
REQ-037 Force beat_count to 0xFFFF via 65535 transfers, then one more -> beat_count = 0x0000.
REQ-038 DATA_WIDTH_OUT=DATA_WIDTH_IN=12, s_data 0x5A5 any mode -> m_data 0x5A5 at latency 2.
